nios_debug_ocimem_engine: RTL and testbench

- Debug memory access engine directly downstream of the Nios II debug slave wrapper.
- Consumes the clk-domain jdo word and take_action_ocimem_a/b / take_no_action_ocimem_a strobes. Performs reads and writes to an internal 32-bit debug RAM, and returns read data on MonDReg for the wrapper to shift out.
- Also exposes an Avalon-MM slave so the CPU can execute from and access the same RAM, with arbitration between the JTAG and CPU sides.

---
 rtl/nios_debug_ocimem_engine.sv | 188 ++++++++++++++++++
 tb/tb_nios_debug_ocimem_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_ocimem_engine.sv
// Debug memory access engine sitting behind the Nios II debug slave wrapper.
// JTAG commands (address load / write / read) and an Avalon-MM CPU port
// share one 32-bit debug RAM; JTAG always wins arbitration in IDLE.
//
// state | meaning
// IDLE  | waiting; arbitrates pending/live JTAG command vs CPU request
// J_RD  | JTAG read: RAM read at jtag_addr
// J_CAP | JTAG read: MonDReg captures RAM data, jtag_addr++
// J_WR  | JTAG write: RAM write at jtag_addr, jtag_addr++
// C_RD  | CPU read: RAM read at avs_address into avs_readdata
// C_ACK | CPU access acknowledged (waitrequest low for this cycle)
module nios_debug_ocimem_engine #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] INIT_MONDREG = 32'h0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_debugaccess,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);
    typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, C_RD, C_ACK} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_B, CMD_N} cmd_t;

    state_t            state, state_nxt;
    logic [31:0]       ram [2**ADDR_W];
    logic [ADDR_W-1:0] jtag_addr;
    logic [31:0]       jtag_wdata;
    logic [31:0]       jtag_rdata;
    logic              pend_vld;
    cmd_t              pend_cmd;
    logic [35:3]       pend_jdo;
    cmd_t              live_cmd;
    logic              live_multi;
    cmd_t              sel_cmd;
    logic [35:3]       sel_jdo;
    logic              addr_load, addr_inc, wdata_load, pend_take, jtag_we, cpu_we;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Live strobe decode with fixed priority a > b > no_action.
    always_comb begin
        live_cmd = CMD_NONE;
        if (take_action_ocimem_a)         live_cmd = CMD_A;
        else if (take_action_ocimem_b)    live_cmd = CMD_B;
        else if (take_no_action_ocimem_a) live_cmd = CMD_N;
    end

    assign live_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);

    // A pending command is always older than a live one, so it is served first.
    assign sel_cmd = pend_vld ? pend_cmd : live_cmd;
    assign sel_jdo = pend_vld ? pend_jdo : jdo[35:3];

    assign jtag_busy       = (state == J_RD) || (state == J_CAP) || (state == J_WR) || pend_vld;
    assign avs_waitrequest = (state != C_ACK);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt  = state;
        addr_load  = 1'b0;
        addr_inc   = 1'b0;
        wdata_load = 1'b0;
        pend_take  = 1'b0;
        jtag_we    = 1'b0;
        cpu_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_cmd != CMD_NONE) begin
                    pend_take = pend_vld;
                    case (sel_cmd)
                        CMD_A: begin
                            addr_load = 1'b1;
                            if (sel_jdo[35]) state_nxt = J_RD;
                        end
                        CMD_B: begin
                            wdata_load = 1'b1;
                            state_nxt  = J_WR;
                        end
                        default: state_nxt = J_RD;
                    endcase
                end else if (avs_read) begin
                    state_nxt = C_RD;
                end else if (avs_write) begin
                    cpu_we    = avs_debugaccess;
                    state_nxt = C_ACK;
                end
            end
            J_RD:  state_nxt = J_CAP;
            J_CAP: begin
                addr_inc  = 1'b1;
                state_nxt = IDLE;
            end
            J_WR: begin
                jtag_we   = 1'b1;
                addr_inc  = 1'b1;
                state_nxt = IDLE;
            end
            C_RD:  state_nxt = C_ACK;
            C_ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One-deep pending slot: filled by a strobe that arrives while the FSM is busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld <= 1'b0;
            pend_cmd <= CMD_NONE;
            pend_jdo <= '0;
        end else begin
            if (pend_take) pend_vld <= 1'b0;
            if ((live_cmd != CMD_NONE) && !pend_vld && (state != IDLE)) begin
                pend_vld <= 1'b1;
                pend_cmd <= live_cmd;
                pend_jdo <= jdo[35:3];
            end
        end
    end

    // Sticky overrun: a lost strobe outranks the clear from ocimem_a.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            jtag_overrun <= 1'b0;
        else if (live_multi || ((live_cmd != CMD_NONE) && pend_vld))
            jtag_overrun <= 1'b1;
        else if (take_action_ocimem_a)
            jtag_overrun <= 1'b0;
    end

    // JTAG address (load beats increment, wraps naturally) and write data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr  <= '0;
            jtag_wdata <= '0;
        end else begin
            if (addr_load)     jtag_addr <= sel_jdo[17+ADDR_W-1:17];
            else if (addr_inc) jtag_addr <= jtag_addr + 1'b1;
            if (wdata_load)    jtag_wdata <= sel_jdo[34:3];
        end
    end

    // RAM write port; gated by reset_n so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (jtag_we) begin
                ram[jtag_addr] <= jtag_wdata;
            end else if (cpu_we) begin
                for (int i = 0; i < 4; i++)
                    if (avs_byteenable[i]) ram[avs_address][8*i +: 8] <= avs_writedata[8*i +: 8];
            end
        end
    end

    // Read data registers for the JTAG and CPU sides.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonDReg      <= INIT_MONDREG;
            jtag_rdata   <= '0;
            avs_readdata <= '0;
        end else begin
            if (state == J_RD)  jtag_rdata   <= ram[jtag_addr];
            if (state == J_CAP) MonDReg      <= jtag_rdata;
            if (state == C_RD)  avs_readdata <= ram[avs_address];
        end
    end
endmodule

// File: tb/tb_nios_debug_ocimem_engine.sv
// Directed bench for the debug memory access engine.
module tb_nios_debug_ocimem_engine;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0, take_b = 1'b0, take_n = 1'b0;
    logic [31:0] MonDReg;
    logic        jtag_busy, jtag_overrun;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic        avs_debugaccess = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    int n_cmp = 0;
    int n_bad = 0;

    nios_debug_ocimem_engine #(.ADDR_W(8), .INIT_MONDREG(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
        .take_no_action_ocimem_a(take_n),
        .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_debugaccess(avs_debugaccess), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] addr, input logic rd);
        jdo = '0; jdo[24:17] = addr; jdo[35] = rd; take_a = 1'b1;
        tick();
        take_a = 1'b0; jdo = '0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = '0; jdo[34:3] = data; take_b = 1'b1;
        tick();
        take_b = 1'b0; jdo = '0;
    endtask

    task automatic pulse_n();
        take_n = 1'b1;
        tick();
        take_n = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic dbg, output int waits);
        avs_address = addr; avs_writedata = data; avs_byteenable = be;
        avs_debugaccess = dbg; avs_write = 1'b1; waits = 0;
        while (avs_waitrequest && waits < 20) begin
            waits++;
            tick();
        end
        tick();
        avs_write = 1'b0; avs_debugaccess = 1'b0;
        if (waits >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL cpu_write_timeout addr=%h waitrequest never dropped", addr);
        end
    endtask

    task automatic cpu_read(input logic [7:0] addr, output logic [31:0] data, output int waits);
        avs_address = addr; avs_read = 1'b1; waits = 0; data = 'x;
        while (avs_waitrequest && waits < 20) begin
            waits++;
            tick();
        end
        if (waits < 20) data = avs_readdata;
        tick();
        avs_read = 1'b0;
        if (waits >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL cpu_read_timeout addr=%h waitrequest never dropped", addr);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        n_cmp++; if (MonDReg !== 32'h0) begin n_bad++; $display("FAIL rst_mondreg got=%h exp=%h", MonDReg, 32'h0); end
        n_cmp++; if (jtag_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", jtag_busy); end
        n_cmp++; if (jtag_overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got=%b exp=0", jtag_overrun); end
        n_cmp++; if (avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rst_waitreq got=%b exp=1", avs_waitrequest); end
        n_cmp++; if (avs_readdata !== 32'h0) begin n_bad++; $display("FAIL rst_readdata got=%h exp=0", avs_readdata); end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_preload();
        int w; logic [31:0] d;
        cpu_write(8'h11, 32'h12345678, 4'hF, 1'b1, w);
        n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL cpu_wr_latency got=%0d exp=1", w); end
        cpu_read(8'h11, d, w);
        n_cmp++; if (w !== 2) begin n_bad++; $display("FAIL cpu_rd_latency got=%0d exp=2", w); end
        n_cmp++; if (d !== 32'h12345678) begin n_bad++; $display("FAIL cpu_rd_data got=%h exp=%h", d, 32'h12345678); end
    endtask

    task automatic test_addr_write();
        int w; logic [31:0] d;
        pulse_a(8'h10, 1'b0);
        n_cmp++; if (jtag_busy !== 1'b0) begin n_bad++; $display("FAIL addr_only_busy got=%b exp=0", jtag_busy); end
        pulse_b(32'hDEADBEEF);
        n_cmp++; if (jtag_busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy got=%b exp=1", jtag_busy); end
        tick();
        n_cmp++; if (jtag_busy !== 1'b0) begin n_bad++; $display("FAIL wr_done_busy got=%b exp=0", jtag_busy); end
        cpu_read(8'h10, d, w);
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL jtag_wr_data got=%h exp=%h", d, 32'hDEADBEEF); end
    endtask

    task automatic test_read_back();
        pulse_a(8'h10, 1'b1);
        n_cmp++; if (MonDReg !== 32'h0) begin n_bad++; $display("FAIL rd_early_n1 got=%h exp=0", MonDReg); end
        tick();
        n_cmp++; if (MonDReg !== 32'h0) begin n_bad++; $display("FAIL rd_early_n2 got=%h exp=0", MonDReg); end
        tick();
        n_cmp++; if (MonDReg !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_back got=%h exp=%h", MonDReg, 32'hDEADBEEF); end
        pulse_n();
        tick(); tick();
        n_cmp++; if (MonDReg !== 32'h12345678) begin n_bad++; $display("FAIL rd_incr got=%h exp=%h", MonDReg, 32'h12345678); end
    endtask

    task automatic test_wrap();
        int w; logic [31:0] d;
        pulse_a(8'hFF, 1'b0);
        pulse_b(32'hCAFEF00D);
        tick();
        pulse_b(32'h0BADF00D);
        tick();
        pulse_a(8'hFF, 1'b1);
        tick(); tick();
        n_cmp++; if (MonDReg !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrap_ff got=%h exp=%h", MonDReg, 32'hCAFEF00D); end
        pulse_n();
        tick(); tick();
        n_cmp++; if (MonDReg !== 32'h0BADF00D) begin n_bad++; $display("FAIL wrap_00_jtag got=%h exp=%h", MonDReg, 32'h0BADF00D); end
        cpu_read(8'h00, d, w);
        n_cmp++; if (d !== 32'h0BADF00D) begin n_bad++; $display("FAIL wrap_00_cpu got=%h exp=%h", d, 32'h0BADF00D); end
    endtask

    task automatic test_contention();
        int cnt; logic [31:0] d;
        pulse_a(8'h10, 1'b0);
        avs_address = 8'h10; avs_read = 1'b1;
        jdo = '0; jdo[34:3] = 32'h55AA55AA; take_b = 1'b1;
        cnt = 0; d = 'x;
        while (avs_waitrequest && cnt < 20) begin
            cnt++;
            tick();
            take_b = 1'b0; jdo = '0;
        end
        d = avs_readdata;
        tick();
        avs_read = 1'b0;
        n_cmp++; if (cnt !== 4) begin n_bad++; $display("FAIL contention_waits got=%0d exp=4", cnt); end
        n_cmp++; if (d !== 32'h55AA55AA) begin n_bad++; $display("FAIL contention_data got=%h exp=%h", d, 32'h55AA55AA); end
    endtask

    task automatic test_overrun();
        int w; logic [31:0] d;
        cpu_write(8'h22, 32'h0, 4'hF, 1'b1, w);
        pulse_a(8'h20, 1'b0);
        pulse_b(32'h11111111);
        pulse_b(32'h22222222);
        pulse_b(32'h33333333);
        n_cmp++; if (jtag_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set got=%b exp=1", jtag_overrun); end
        n_cmp++; if (jtag_busy !== 1'b1) begin n_bad++; $display("FAIL overrun_busy got=%b exp=1", jtag_busy); end
        tick(); tick();
        n_cmp++; if (jtag_busy !== 1'b0) begin n_bad++; $display("FAIL overrun_idle got=%b exp=0", jtag_busy); end
        n_cmp++; if (jtag_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky got=%b exp=1", jtag_overrun); end
        cpu_read(8'h20, d, w);
        n_cmp++; if (d !== 32'h11111111) begin n_bad++; $display("FAIL overrun_first got=%h exp=%h", d, 32'h11111111); end
        cpu_read(8'h21, d, w);
        n_cmp++; if (d !== 32'h22222222) begin n_bad++; $display("FAIL overrun_pended got=%h exp=%h", d, 32'h22222222); end
        cpu_read(8'h22, d, w);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL overrun_dropped got=%h exp=0", d); end
        pulse_a(8'h40, 1'b0);
        n_cmp++; if (jtag_overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear got=%b exp=0", jtag_overrun); end
        // a and b together: a wins as address-only load, b is lost
        jdo = '0; jdo[24:17] = 8'h50; jdo[34:3] = 32'hFFFF0000; jdo[35] = 1'b0;
        take_a = 1'b1; take_b = 1'b1;
        tick();
        take_a = 1'b0; take_b = 1'b0; jdo = '0;
        n_cmp++; if (jtag_overrun !== 1'b1) begin n_bad++; $display("FAIL multi_overrun got=%b exp=1", jtag_overrun); end
        n_cmp++; if (jtag_busy !== 1'b0) begin n_bad++; $display("FAIL multi_busy got=%b exp=0", jtag_busy); end
        pulse_a(8'h40, 1'b0);
    endtask

    task automatic test_protect();
        int w; logic [31:0] d;
        cpu_write(8'h10, 32'hFFFFFFFF, 4'hF, 1'b0, w);
        n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL prot_waits got=%0d exp=1", w); end
        n_cmp++; if (avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL prot_wr_once got=%b exp=1", avs_waitrequest); end
        cpu_read(8'h10, d, w);
        n_cmp++; if (d !== 32'h55AA55AA) begin n_bad++; $display("FAIL prot_data got=%h exp=%h", d, 32'h55AA55AA); end
        cpu_write(8'h10, 32'hA1B2C3D4, 4'b0101, 1'b1, w);
        cpu_read(8'h10, d, w);
        n_cmp++; if (d !== 32'h55B255D4) begin n_bad++; $display("FAIL byteen_data got=%h exp=%h", d, 32'h55B255D4); end
    endtask

    task automatic test_reset_mid();
        int w; logic [31:0] d;
        cpu_write(8'h30, 32'hA5A5A5A5, 4'hF, 1'b1, w);
        pulse_a(8'h10, 1'b1);
        n_cmp++; if (jtag_busy !== 1'b1) begin n_bad++; $display("FAIL jrd_busy got=%b exp=1", jtag_busy); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (MonDReg !== 32'h0) begin n_bad++; $display("FAIL mid_rst_mondreg got=%h exp=0", MonDReg); end
        n_cmp++; if (avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL mid_rst_waitreq got=%b exp=1", avs_waitrequest); end
        n_cmp++; if (jtag_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got=%b exp=0", jtag_busy); end
        #2 reset_n = 1'b1;
        tick();
        pulse_a(8'h30, 1'b0);
        pulse_b(32'h77777777);
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        cpu_read(8'h30, d, w);
        n_cmp++; if (d !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL jwr_abort got=%h exp=%h", d, 32'hA5A5A5A5); end
    endtask

    initial begin
        test_reset();
        test_cpu_preload();
        test_addr_write();
        test_read_back();
        test_wrap();
        test_contention();
        test_overrun();
        test_protect();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end
endmodule
